// File: rtl/sliding_window_framer.sv
// Sliding-window framer: buffers NP complex samples, emits a windowed frame every L new samples.
// Define SWF_SATURATE_EN to clamp scaled products instead of wrapping them.
module sliding_window_framer #(
    parameter int NP         = 1024,
    parameter int L          = 256,
    parameter int NB_INPUT   = 16,
    parameter int NBF_INPUT  = 14,
    parameter int NB_WIND    = 16,
    parameter int NBF_WIND   = 14,
    parameter int NB_OUTPUT  = 16,
    parameter int NBF_OUTPUT = 14
) (
    input  logic                          clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [NB_INPUT-1:0]           i_x_re,
    input  logic [NB_INPUT-1:0]           i_x_im,
    input  logic [NP*NB_WIND-1:0]         i_window_frame,
    output logic [2*NP*NB_OUTPUT-1:0]     o_concat_frame,
    output logic                          o_valid_frame,
    input  logic                          i_ready
);

    localparam int NB_PROD = NB_INPUT + NB_WIND;
    localparam int S       = NBF_INPUT + NBF_WIND - NBF_OUTPUT;
    localparam int CW      = $clog2(NP + 1);

    localparam logic signed [NB_PROD:0] OUT_MAX =
        (NB_PROD+1)'((64'sd1 <<< (NB_OUTPUT - 1)) - 64'sd1);
    localparam logic signed [NB_PROD:0] OUT_MIN = -OUT_MAX - 1;

    typedef enum logic [1:0] {FILL, SLIDE, HOLD} state_t;

    state_t                      state;
    logic [CW-1:0]               count;
    logic signed [NB_INPUT-1:0]  win_re [NP];
    logic signed [NB_INPUT-1:0]  win_im [NP];
    logic signed [NB_INPUT-1:0]  nxt_re [NP];
    logic signed [NB_INPUT-1:0]  nxt_im [NP];
    logic [2*NP*NB_OUTPUT-1:0]   frame_next;
    logic                        accept;
    logic                        last;

    // Full-precision product, round-half-up, then reduce to the output width.
    function automatic logic [NB_OUTPUT-1:0] scale(input logic signed [NB_INPUT-1:0] x,
                                                   input logic signed [NB_WIND-1:0] c);
        logic signed [NB_PROD:0] p;
        logic signed [NB_PROD:0] r;
        p = (NB_PROD+1)'(x) * (NB_PROD+1)'(c);
        r = (p + (NB_PROD+1)'(64'sd1 <<< (S - 1))) >>> S;
`ifdef SWF_SATURATE_EN
        if (r > OUT_MAX) begin
            r = OUT_MAX;
        end else if (r < OUT_MIN) begin
            r = OUT_MIN;
        end
`endif
        return r[NB_OUTPUT-1:0];
    endfunction

    assign o_ready = i_enable && !i_reset && (state != HOLD);
    assign accept  = i_valid && o_ready;
    assign last    = (state == FILL) ? (count == CW'(NP - 1)) : (count == CW'(L - 1));

    // The frame is computed from the post-shift buffer so it is ready the cycle after completion.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < NP - 1; k++) begin
            nxt_re[k] = win_re[k+1];
            nxt_im[k] = win_im[k+1];
        end
        nxt_re[NP-1] = i_x_re;
        nxt_im[NP-1] = i_x_im;
        for (int k = 0; k < NP; k++) begin
            frame_next[k*NB_OUTPUT +: NB_OUTPUT] =
                scale(nxt_re[k], i_window_frame[k*NB_WIND +: NB_WIND]);
            frame_next[(NP+k)*NB_OUTPUT +: NB_OUTPUT] =
                scale(nxt_im[k], i_window_frame[k*NB_WIND +: NB_WIND]);
        end
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state          <= FILL;
            count          <= '0;
            o_valid_frame  <= 1'b0;
            o_concat_frame <= '0;
            for (int k = 0; k < NP; k++) begin
                win_re[k] <= '0;
                win_im[k] <= '0;
            end
        end else if (i_enable) begin
            if (accept) begin
                for (int k = 0; k < NP; k++) begin
                    win_re[k] <= nxt_re[k];
                    win_im[k] <= nxt_im[k];
                end
                if (last) begin
                    state          <= HOLD;
                    count          <= '0;
                    o_concat_frame <= frame_next;
                    o_valid_frame  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end else if (state == HOLD && i_ready) begin
                state          <= SLIDE;
                count          <= '0;
                o_valid_frame  <= 1'b0;
                o_concat_frame <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sliding_window_framer.sv
// Randomised self-checking bench for sliding_window_framer against a queue-based frame model.
module tb_sliding_window_framer;

    localparam int NP = 8;
    localparam int L  = 2;
    localparam int NB = 16;
    localparam int FW = 2*NP*NB;

    logic            clock = 1'b0;
    logic            i_reset, i_enable, i_valid, i_ready;
    logic            o_ready, o_valid_frame;
    logic [NB-1:0]   i_x_re, i_x_im;
    logic [NP*NB-1:0] i_window_frame;
    logic [FW-1:0]   o_concat_frame;

    always #5 clock = ~clock;

    sliding_window_framer #(
        .NP(NP), .L(L),
        .NB_INPUT(16), .NBF_INPUT(14),
        .NB_WIND(16), .NBF_WIND(14),
        .NB_OUTPUT(16), .NBF_OUTPUT(14)
    ) dut (
        .clock          (clock),
        .i_reset        (i_reset),
        .i_enable       (i_enable),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_x_re         (i_x_re),
        .i_x_im         (i_x_im),
        .i_window_frame (i_window_frame),
        .o_concat_frame (o_concat_frame),
        .o_valid_frame  (o_valid_frame),
        .i_ready        (i_ready)
    );

    // Model: history of accepted samples since reset, oldest first; {im, re} per entry.
    logic [2*NB-1:0] hist[$];
    int              m_cnt;
    bit              m_filled;
    bit              m_valid;
    logic [FW-1:0]   m_frame;
    int              n_pass = 0;
    int              n_total = 0;

    function automatic logic [NB-1:0] red(input logic signed [NB-1:0] x,
                                          input logic signed [NB-1:0] c);
        longint p;
        p = (longint'(x) * longint'(c) + 64'sd8192) >>> 14;
`ifdef SWF_SATURATE_EN
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
`endif
        return p[NB-1:0];
    endfunction

    function automatic logic exp_ready();
        return i_enable && !i_reset && !m_valid;
    endfunction

    task automatic step(input logic v, input logic [NB-1:0] re, input logic [NB-1:0] im,
                        input logic rdy, input logic en, input logic rst);
        bit acc;
        logic [2*NB-1:0] e;
        i_valid  = v;
        i_x_re   = re;
        i_x_im   = im;
        i_ready  = rdy;
        i_enable = en;
        i_reset  = rst;
        acc = v && en && !rst && !m_valid;
        @(posedge clock);
        if (rst) begin
            hist.delete();
            m_cnt = 0; m_filled = 0; m_valid = 0; m_frame = '0;
        end else if (en) begin
            if (acc) begin
                hist.push_back({im, re});
                if (hist.size() > NP) void'(hist.pop_front());
                m_cnt++;
                if (m_cnt == (m_filled ? L : NP)) begin
                    for (int k = 0; k < NP; k++) begin
                        e = hist[k];
                        m_frame[k*NB +: NB]      = red(e[NB-1:0], i_window_frame[k*NB +: NB]);
                        m_frame[(NP+k)*NB +: NB] = red(e[2*NB-1:NB], i_window_frame[k*NB +: NB]);
                    end
                    m_valid = 1; m_filled = 1; m_cnt = 0;
                end
            end else if (m_valid && rdy) begin
                m_valid = 0;
                m_frame = '0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        i_window_frame = '0;
        for (int c = 0; c < 3; c++) begin
            step(1, 16'h1234, 16'h5678, 1, 1, 1);
            n_total++;
            if (o_ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", o_ready);
            else n_pass++;
            n_total++;
            if (o_valid_frame !== 1'b0) $display("FAIL reset_valid got %b exp 0", o_valid_frame);
            else n_pass++;
            n_total++;
            if (o_concat_frame !== '0) $display("FAIL reset_frame got %h exp 0", o_concat_frame);
            else n_pass++;
        end
    endtask

    task automatic test_fill_ramp();
        logic [NB-1:0] er;
        for (int k = 0; k < NP; k++) i_window_frame[k*NB +: NB] = 16'h4000;
        for (int k = 0; k < NP; k++) begin
            step(1, 16'(k * 16'h0400), 16'h0000, 0, 1, 0);
            n_total++;
            if (o_valid_frame !== (k == NP - 1))
                $display("FAIL fill_valid k=%0d got %b exp %b", k, o_valid_frame, k == NP - 1);
            else n_pass++;
        end
        for (int k = 0; k < NP; k++) begin
            er = 16'(k * 16'h0400);
            n_total++;
            if (o_concat_frame[k*NB +: NB] !== er || o_concat_frame[(NP+k)*NB +: NB] !== 16'h0)
                $display("FAIL fill_frame k=%0d got re %h im %h exp re %h im 0", k,
                         o_concat_frame[k*NB +: NB], o_concat_frame[(NP+k)*NB +: NB], er);
            else n_pass++;
        end
        n_total++;
        if (o_ready !== 1'b0) $display("FAIL fill_hold_ready got %b exp 0", o_ready);
        else n_pass++;
    endtask

    task automatic test_slide();
        logic [NB-1:0] er;
        step(1, 16'h2000, 16'h0000, 1, 1, 0);
        n_total++;
        if (o_valid_frame !== 1'b0 || o_concat_frame !== '0 || o_ready !== 1'b1)
            $display("FAIL slide_release got valid %b ready %b frame %h exp 0 1 0",
                     o_valid_frame, o_ready, o_concat_frame);
        else n_pass++;
        step(1, 16'h2000, 16'h0000, 1, 1, 0);
        step(1, 16'h2400, 16'h0000, 1, 1, 0);
        n_total++;
        if (o_valid_frame !== 1'b1) $display("FAIL slide_valid got %b exp 1", o_valid_frame);
        else n_pass++;
        for (int k = 0; k < NP; k++) begin
            er = 16'((k + 2) * 16'h0400);
            n_total++;
            if (o_concat_frame[k*NB +: NB] !== er)
                $display("FAIL slide_frame k=%0d got %h exp %h", k, o_concat_frame[k*NB +: NB], er);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] held;
        held = m_frame;
        for (int c = 0; c < 5; c++) begin
            step(1, 16'($urandom), 16'($urandom), 0, 1, 0);
            n_total++;
            if (o_ready !== 1'b0 || o_valid_frame !== 1'b1 || o_concat_frame !== held)
                $display("FAIL bp_hold c=%0d got ready %b valid %b frame %h exp 0 1 %h",
                         c, o_ready, o_valid_frame, o_concat_frame, held);
            else n_pass++;
        end
        step(1, 16'($urandom), 16'($urandom), 1, 1, 0);
        n_total++;
        if (o_valid_frame !== 1'b0 || o_concat_frame !== '0 || o_ready !== 1'b1)
            $display("FAIL bp_release got valid %b ready %b frame %h exp 0 1 0",
                     o_valid_frame, o_ready, o_concat_frame);
        else n_pass++;
        step(1, 16'($urandom), 16'($urandom), 0, 1, 0);
        n_total++;
        if (o_valid_frame !== m_valid || o_ready !== exp_ready())
            $display("FAIL bp_resume got valid %b ready %b exp %b %b",
                     o_valid_frame, o_ready, m_valid, exp_ready());
        else n_pass++;
    endtask

    task automatic test_enable();
        logic [FW-1:0] held;
        for (int c = 0; c < 3; c++) begin
            step(1, 16'($urandom), 16'($urandom), 1, 0, 0);
            n_total++;
            if (o_ready !== 1'b0 || o_valid_frame !== 1'b0)
                $display("FAIL en_slide got ready %b valid %b exp 0 0", o_ready, o_valid_frame);
            else n_pass++;
        end
        step(1, 16'h1111, 16'hEEEE, 0, 1, 0);
        n_total++;
        if (o_valid_frame !== m_valid || o_concat_frame !== m_frame)
            $display("FAIL en_frame got valid %b frame %h exp %b %h",
                     o_valid_frame, o_concat_frame, m_valid, m_frame);
        else n_pass++;
        held = m_frame;
        for (int c = 0; c < 3; c++) begin
            step(0, 16'h0, 16'h0, 1, 0, 0);
            n_total++;
            if (o_valid_frame !== 1'b1 || o_concat_frame !== held || o_ready !== 1'b0)
                $display("FAIL en_hold c=%0d got valid %b ready %b frame %h exp 1 0 %h",
                         c, o_valid_frame, o_ready, o_concat_frame, held);
            else n_pass++;
        end
        step(0, 16'h0, 16'h0, 1, 1, 0);
        n_total++;
        if (o_valid_frame !== 1'b0) $display("FAIL en_release got %b exp 0", o_valid_frame);
        else n_pass++;
    endtask

    task automatic test_reset_midfill();
        logic [NB-1:0] s_re [NP];
        for (int k = 0; k < NP; k++) i_window_frame[k*NB +: NB] = 16'h4000;
        step(0, 16'h0, 16'h0, 0, 1, 1);
        for (int c = 0; c < 5; c++) step(1, 16'($urandom), 16'($urandom), 0, 1, 0);
        step(1, 16'h7777, 16'h7777, 0, 1, 1);
        for (int k = 0; k < NP; k++) begin
            s_re[k] = 16'($urandom);
            step(1, s_re[k], 16'($urandom), 0, 1, 0);
            n_total++;
            if (o_valid_frame !== (k == NP - 1))
                $display("FAIL midfill_valid k=%0d got %b exp %b", k, o_valid_frame, k == NP - 1);
            else n_pass++;
        end
        for (int k = 0; k < NP; k++) begin
            n_total++;
            if (o_concat_frame[k*NB +: NB] !== s_re[k])
                $display("FAIL midfill_frame k=%0d got %h exp %h", k,
                         o_concat_frame[k*NB +: NB], s_re[k]);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        logic [NB-1:0] exp_re, exp_im;
`ifdef SWF_SATURATE_EN
        exp_re = 16'h7FFF; exp_im = 16'h8000;
`else
        exp_re = 16'hFFFC; exp_im = 16'h0002;
`endif
        for (int k = 0; k < NP; k++) i_window_frame[k*NB +: NB] = 16'h7FFF;
        step(0, 16'h0, 16'h0, 0, 1, 1);
        for (int k = 0; k < NP; k++) step(1, 16'h7FFF, 16'h8000, 0, 1, 0);
        n_total++;
        if (o_concat_frame[(NP-1)*NB +: NB] !== exp_re || o_concat_frame[(2*NP-1)*NB +: NB] !== exp_im)
            $display("FAIL sat_corner got re %h im %h exp re %h im %h",
                     o_concat_frame[(NP-1)*NB +: NB], o_concat_frame[(2*NP-1)*NB +: NB],
                     exp_re, exp_im);
        else n_pass++;
        n_total++;
        if (o_concat_frame !== m_frame)
            $display("FAIL sat_frame got %h exp %h", o_concat_frame, m_frame);
        else n_pass++;
    endtask

    task automatic test_random();
        step(0, 16'h0, 16'h0, 0, 1, 1);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 15) == 0)
                for (int k = 0; k < NP; k++) i_window_frame[k*NB +: NB] = 16'($urandom);
            step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0);
            n_total++;
            if (o_valid_frame !== m_valid || o_concat_frame !== m_frame || o_ready !== exp_ready())
                $display("FAIL rand c=%0d got valid %b ready %b frame %h exp %b %b %h", c,
                         o_valid_frame, o_ready, o_concat_frame, m_valid, exp_ready(), m_frame);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_ramp();
        test_slide();
        test_backpressure();
        test_enable();
        test_reset_midfill();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
